rr_arbiter_ctrl: RTL and testbench

- Round-robin arbiter/scheduler that shares one resource among N requesters.
- Uses a registered one-hot grant, a per-grant hold timer with forced preemption, and a one-cycle release gap between owners.
- Sits in front of any shared datapath driven by posedge clk.
- Can embed concurrent assertions; these evaluate on preponed (sampled) values, so they check exactly what the grant logic saw at each edge.

---
 rtl/rr_arbiter_ctrl.sv | 178 +++++++++++++++++
 tb/tb_rr_arbiter_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_ctrl.sv
// Round-robin arbiter: registered one-hot grant, per-owner hold limit with forced
// preemption, and a one-cycle release gap. Define ARB_ASSERT_EN to embed checkers.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | no owner; arbitrate from last_id+1 on every edge
// ST_GRANT   | gnt_id owns the resource; hold_left counts down to preemption
// ST_RELEASE | one cycle with gnt low before arbitration resumes
module rr_arbiter_ctrl #(
   parameter  int N_REQ    = 4,
   parameter  int MAX_HOLD = 8,
   localparam int ID_W     = $clog2(N_REQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_REQ-1:0]  req,
   output logic [N_REQ-1:0]  gnt,
   output logic              gnt_valid,
   output logic [ID_W-1:0]   gnt_id,
   output logic              timeout,
   output logic [7:0]        busy_cnt
);

   localparam int HOLD_W = $clog2(MAX_HOLD);
   localparam logic [N_REQ-1:0] GNT_ONE  = {{(N_REQ-1){1'b0}}, 1'b1};
   localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_REQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [N_REQ-1:0]   gnt_nxt;
   logic               gnt_valid_nxt;
   logic [ID_W-1:0]    gnt_id_nxt;
   logic               timeout_nxt;
   logic [7:0]         busy_cnt_nxt;
   logic [HOLD_W-1:0]  hold_left, hold_left_nxt;
   logic [ID_W-1:0]    last_id, last_id_nxt;

   logic               sel_found;
   logic [ID_W-1:0]    sel_id;
   int                 scan_idx;

   // Rotating priority scan: last_id+1 first, wrapping modulo N_REQ.
   always_comb begin
      sel_found = 1'b0;
      sel_id    = '0;
      scan_idx  = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         scan_idx = (int'(last_id) + k) % N_REQ;
         if (!sel_found && req[scan_idx[ID_W-1:0]]) begin
            sel_found = 1'b1;
            sel_id    = scan_idx[ID_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         gnt       <= '0;
         gnt_valid <= 1'b0;
         gnt_id    <= '0;
         timeout   <= 1'b0;
         busy_cnt  <= '0;
         hold_left <= '0;
         last_id   <= LAST_RST;
      end else begin
         state     <= state_nxt;
         gnt       <= gnt_nxt;
         gnt_valid <= gnt_valid_nxt;
         gnt_id    <= gnt_id_nxt;
         timeout   <= timeout_nxt;
         busy_cnt  <= busy_cnt_nxt;
         hold_left <= hold_left_nxt;
         last_id   <= last_id_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      gnt_nxt       = gnt;
      gnt_valid_nxt = gnt_valid;
      gnt_id_nxt    = gnt_id;
      timeout_nxt   = 1'b0;
      busy_cnt_nxt  = busy_cnt;
      hold_left_nxt = hold_left;
      last_id_nxt   = last_id;

      case (state)
         ST_IDLE: begin
            gnt_nxt       = '0;
            gnt_valid_nxt = 1'b0;
            gnt_id_nxt    = '0;
            if (sel_found) begin
               gnt_nxt       = GNT_ONE << sel_id;
               gnt_valid_nxt = 1'b1;
               gnt_id_nxt    = sel_id;
               hold_left_nxt = HOLD_W'(MAX_HOLD - 1);
               if (busy_cnt != 8'hFF)
                  busy_cnt_nxt = busy_cnt + 8'd1;
               state_nxt     = ST_GRANT;
            end
         end

         // Release is tested before the hold limit so a same-edge drop never pulses timeout.
         ST_GRANT: begin
            if (!req[gnt_id] || (hold_left == '0)) begin
               gnt_nxt       = '0;
               gnt_valid_nxt = 1'b0;
               gnt_id_nxt    = '0;
               last_id_nxt   = gnt_id;
               timeout_nxt   = req[gnt_id];
               state_nxt     = ST_RELEASE;
            end else begin
               hold_left_nxt = hold_left - HOLD_W'(1);
            end
         end

         ST_RELEASE: begin
            gnt_nxt       = '0;
            gnt_valid_nxt = 1'b0;
            gnt_id_nxt    = '0;
            state_nxt     = ST_IDLE;
         end

         default: begin
            gnt_nxt       = '0;
            gnt_valid_nxt = 1'b0;
            gnt_id_nxt    = '0;
            state_nxt     = ST_IDLE;
         end
      endcase
   end

`ifdef ARB_ASSERT_EN
   a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt))
      else $error("[%0t] gnt not one-hot, gnt_id=%0d", $time, gnt_id);

   a_valid: assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt))
      else $error("[%0t] gnt_valid disagrees with gnt, gnt_id=%0d", $time, gnt_id);

   a_tmo_idle: assert property (@(posedge clk) disable iff (!rst_n) timeout |-> (gnt == '0))
      else $error("[%0t] timeout while granted, gnt_id=%0d", $time, gnt_id);

   a_valid_gap: assert property (@(posedge clk) disable iff (!rst_n)
                                 $rose(gnt_valid) |-> !$past(gnt_valid))
      else $error("[%0t] gnt_valid rose without a low cycle, gnt_id=%0d", $time, gnt_id);

   for (genvar i = 0; i < N_REQ; i++) begin : g_chk
      logic [HOLD_W:0] hi_run;

      // Saturates just past the limit so an overlong grant stays visible.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            hi_run <= '0;
         else if (!gnt[i])
            hi_run <= '0;
         else if (hi_run <= (HOLD_W+1)'(MAX_HOLD))
            hi_run <= hi_run + (HOLD_W+1)'(1);
      end

      a_rise_req: assert property (@(posedge clk) disable iff (!rst_n)
                                   $rose(gnt[i]) |-> $past(req[i]))
         $info("[%0t] grant %0d follows its request, gnt_id=%0d", $time, i, gnt_id);
      else
         $error("[%0t] grant %0d without request, gnt_id=%0d", $time, i, gnt_id);

      a_max_hold: assert property (@(posedge clk) disable iff (!rst_n)
                                   hi_run <= (HOLD_W+1)'(MAX_HOLD))
         else $error("[%0t] grant %0d held too long, gnt_id=%0d", $time, i, gnt_id);
   end
`endif

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// Directed bench for rr_arbiter_ctrl (N_REQ=4, MAX_HOLD=8); inputs driven and
// outputs sampled on the falling edge.
module tb_rr_arbiter_ctrl;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [3:0]  gnt;
   logic        gnt_valid;
   logic [1:0]  gnt_id;
   logic        timeout;
   logic [7:0]  busy_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   rr_arbiter_ctrl #(.N_REQ(4), .MAX_HOLD(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id),
      .timeout   (timeout),
      .busy_cnt  (busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic chk_outs(input string tag, input logic [3:0] e_gnt, input logic e_tmo);
      logic [1:0] e_id;
      e_id = 2'd0;
      for (int i = 0; i < 4; i++) if (e_gnt[i]) e_id = 2'(i);
      chk({tag, ".gnt"},   32'(gnt),       32'(e_gnt));
      chk({tag, ".valid"}, 32'(gnt_valid), 32'(|e_gnt));
      chk({tag, ".id"},    32'(gnt_id),    32'(e_id));
      chk({tag, ".tmo"},   32'(timeout),   32'(e_tmo));
   endtask

   // Constant request pattern: 8 cycles granted, timeout cycle, idle cycle.
   task automatic run_periodic(input string tag, input int ncyc, input bit rotate, input int base);
      int         pos, owner;
      logic [3:0] e_gnt;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         pos   = (c - 1) % 10;
         owner = rotate ? (base + (c - 1) / 10) % 4 : base;
         e_gnt = (pos < 8) ? (4'b0001 << owner) : 4'b0000;
         chk_outs(tag, e_gnt, pos == 8);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req   = '0;

      // reset values
      do_reset();
      chk_outs("rst", 4'b0000, 1'b0);
      chk("rst.busy", 32'(busy_cnt), 32'd0);

      // single requester, 3-cycle hold, normal release
      req = 4'b0001;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk_outs("t1.hold", 4'b0001, 1'b0);
      end
      req = 4'b0000;
      @(negedge clk);
      chk_outs("t1.rel", 4'b0000, 1'b0);
      chk("t1.busy", 32'(busy_cnt), 32'd1);
      @(negedge clk);
      chk_outs("t1.idle", 4'b0000, 1'b0);

      // all requesting: 0,1,2,3,0 each preempted after 8 cycles
      do_reset();
      req = 4'b1111;
      run_periodic("t2", 50, 1'b1, 0);
      chk("t2.busy", 32'(busy_cnt), 32'd5);

      // lone requester is re-granted after its own preemption
      do_reset();
      req = 4'b0100;
      run_periodic("t3", 25, 1'b0, 2);

      // rotation from owner 1 skips to 3, then wraps to 0
      do_reset();
      req = 4'b1010;
      @(negedge clk);
      chk_outs("t4.own1", 4'b0010, 1'b0);
      @(negedge clk);
      req = 4'b1000;
      @(negedge clk);
      chk_outs("t4.rel1", 4'b0000, 1'b0);
      @(negedge clk);
      chk_outs("t4.gap1", 4'b0000, 1'b0);
      @(negedge clk);
      chk_outs("t4.own3", 4'b1000, 1'b0);
      req = 4'b0001;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk_outs("t4.own0", 4'b0001, 1'b0);

      // asynchronous reset mid-grant, then priority restarts at 0
      do_reset();
      req = 4'b1000;
      @(negedge clk);
      chk_outs("t5.own3", 4'b1000, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_outs("t5.async", 4'b0000, 1'b0);
      req = 4'b1001;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_outs("t5.own0", 4'b0001, 1'b0);

      // release on the same edge as the hold limit: no timeout
      do_reset();
      req = 4'b0001;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         chk_outs("t6.hold", 4'b0001, 1'b0);
      end
      req = 4'b0000;
      @(negedge clk);
      chk_outs("t6.rel", 4'b0000, 1'b0);

      // grant counter saturates at 255
      do_reset();
      req = 4'b1111;
      repeat (2541) @(negedge clk);
      chk("t7.busy255", 32'(busy_cnt), 32'd255);
      repeat (60) @(negedge clk);
      chk("t7.sat", 32'(busy_cnt), 32'd255);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
